// File: rtl/ftransform_pipe.sv
// rtl/ftransform_pipe.sv - 2-stage stallable 4x4 VP8 forward DCT / WHT streaming engine
// Optional macro FTX_NZ_EN adds out_nz_o, a registered per-coefficient nonzero mask.
module ftransform_pipe #(
  parameter int I_WIDTH   = 8,
  parameter int DC_WIDTH  = 12,
  parameter int O_WIDTH   = 16,
  parameter int TAG_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   in_mode_i,
  input  logic [TAG_WIDTH-1:0]   in_tag_i,
  input  logic [16*I_WIDTH-1:0]  src_i,
  input  logic [16*I_WIDTH-1:0]  ref_i,
  input  logic [16*DC_WIDTH-1:0] dc_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   out_mode_o,
  output logic [TAG_WIDTH-1:0]   out_tag_o,
  output logic [16*O_WIDTH-1:0]  out_o
`ifdef FTX_NZ_EN
  ,
  output logic [15:0]            out_nz_o
`endif
);
  localparam int SW = 18;
  typedef logic signed [31:0] s32_t;

  function automatic logic [4*SW-1:0] dct_row(input s32_t a0, input s32_t a1,
                                              input s32_t a2, input s32_t a3);
    s32_t b0, b1, b2, b3, t0, t1, t2, t3;
    b0 = a0 + a3;
    b1 = a1 + a2;
    b2 = a1 - a2;
    b3 = a0 - a3;
    t0 = (b0 + b1) <<< 3;
    t2 = (b0 - b1) <<< 3;
    t1 = (b2 * 32'sd2217 + b3 * 32'sd5352 + 32'sd1812) >>> 9;
    t3 = (b3 * 32'sd2217 - b2 * 32'sd5352 + 32'sd937) >>> 9;
    return {SW'(t3), SW'(t2), SW'(t1), SW'(t0)};
  endfunction

  function automatic logic [4*O_WIDTH-1:0] dct_col(input s32_t x0, input s32_t x1,
                                                   input s32_t x2, input s32_t x3);
    s32_t d0, d1, d2, d3, o0, o4, o8, o12;
    d0  = x0 + x3;
    d1  = x1 + x2;
    d2  = x1 - x2;
    d3  = x0 - x3;
    o0  = (d0 + d1 + 32'sd7) >>> 4;
    o8  = (d0 - d1 + 32'sd7) >>> 4;
    // Kept as a signed select so the >>> above stays arithmetic.
    o4  = ((d2 * 32'sd2217 + d3 * 32'sd5352 + 32'sd12000) >>> 16)
        + ((d3 != 32'sd0) ? 32'sd1 : 32'sd0);
    o12 = (d3 * 32'sd2217 - d2 * 32'sd5352 + 32'sd51000) >>> 16;
    return {O_WIDTH'(o12), O_WIDTH'(o8), O_WIDTH'(o4), O_WIDTH'(o0)};
  endfunction

  function automatic logic [4*SW-1:0] wht_row(input s32_t x0, input s32_t x1,
                                              input s32_t x2, input s32_t x3);
    s32_t a0, a1, a2, a3;
    a0 = x0 + x2;
    a1 = x1 + x3;
    a2 = x1 - x3;
    a3 = x0 - x2;
    return {SW'(a0 - a1), SW'(a3 - a2), SW'(a3 + a2), SW'(a0 + a1)};
  endfunction

  function automatic logic [4*O_WIDTH-1:0] wht_col(input s32_t x0, input s32_t x1,
                                                   input s32_t x2, input s32_t x3);
    s32_t a0, a1, a2, a3;
    a0 = x0 + x2;
    a1 = x1 + x3;
    a2 = x1 - x3;
    a3 = x0 - x2;
    return {O_WIDTH'((a0 - a1) >>> 1), O_WIDTH'((a3 - a2) >>> 1),
            O_WIDTH'((a3 + a2) >>> 1), O_WIDTH'((a0 + a1) >>> 1)};
  endfunction

  s32_t                   px [16];
  s32_t                   dx [16];
  s32_t                   tv [16];
  logic [4*SW-1:0]        rowv;
  logic [4*O_WIDTH-1:0]   colv;
  logic [16*SW-1:0]       s1_d, s1_q;
  logic [16*O_WIDTH-1:0]  out_d, out_q;
  logic                   s1_valid_q, s1_mode_q, out_valid_q, out_mode_q;
  logic [TAG_WIDTH-1:0]   s1_tag_q, out_tag_q;
  logic                   adv;

  assign adv        = !out_valid_q || out_ready_i;
  assign in_ready_o = adv || !s1_valid_q;

  // Row pass; the mode mux keeps the inactive lanes out of the stage-1 value.
  always_comb begin
    px   = '{default: '0};
    dx   = '{default: '0};
    rowv = '0;
    s1_d = '0;
    for (int k = 0; k < 16; k++) begin
      px[k] = $signed({{(32-I_WIDTH){1'b0}}, src_i[I_WIDTH*k +: I_WIDTH]})
            - $signed({{(32-I_WIDTH){1'b0}}, ref_i[I_WIDTH*k +: I_WIDTH]});
      dx[k] = 32'($signed(dc_i[DC_WIDTH*k +: DC_WIDTH]));
    end
    for (int i = 0; i < 4; i++) begin
      if (in_mode_i) rowv = wht_row(dx[4*i], dx[4*i+1], dx[4*i+2], dx[4*i+3]);
      else           rowv = dct_row(px[4*i], px[4*i+1], px[4*i+2], px[4*i+3]);
      s1_d[4*SW*i +: 4*SW] = rowv;
    end
  end

  always_comb begin
    tv    = '{default: '0};
    colv  = '0;
    out_d = '0;
    for (int k = 0; k < 16; k++) tv[k] = 32'($signed(s1_q[SW*k +: SW]));
    for (int j = 0; j < 4; j++) begin
      if (s1_mode_q) colv = wht_col(tv[j], tv[4+j], tv[8+j], tv[12+j]);
      else           colv = dct_col(tv[j], tv[4+j], tv[8+j], tv[12+j]);
      for (int r = 0; r < 4; r++) out_d[O_WIDTH*(4*r+j) +: O_WIDTH] = colv[O_WIDTH*r +: O_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_tag_q    <= '0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_mode_q  <= 1'b0;
      out_tag_q   <= '0;
      out_q       <= '0;
    end else begin
      if (in_ready_o) begin
        s1_valid_q <= in_valid_i;
        if (in_valid_i) begin
          s1_mode_q <= in_mode_i;
          s1_tag_q  <= in_tag_i;
          s1_q      <= s1_d;
        end
      end
      if (adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_mode_q <= s1_mode_q;
          out_tag_q  <= s1_tag_q;
          out_q      <= out_d;
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_mode_o  = out_mode_q;
  assign out_tag_o   = out_tag_q;
  assign out_o       = out_q;

`ifdef FTX_NZ_EN
  logic [15:0] nz_d, nz_q;

  always_comb begin
    nz_d = '0;
    for (int k = 0; k < 16; k++) nz_d[k] = |out_d[O_WIDTH*k +: O_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 nz_q <= '0;
    else if (adv && s1_valid_q) nz_q <= nz_d;
  end

  assign out_nz_o = nz_q;
`endif
endmodule

// File: tb/tb_ftransform_pipe.sv
// tb/tb_ftransform_pipe.sv - directed self-checking bench for ftransform_pipe
module tb_ftransform_pipe;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_mode;
  logic [3:0]   in_tag;
  logic [127:0] src, ref_v;
  logic [191:0] dc;
  logic         out_valid, out_ready, out_mode;
  logic [3:0]   out_tag;
  logic [255:0] out_v;
`ifdef FTX_NZ_EN
  logic [15:0]  out_nz;
`endif

  int errors = 0;
  int checks = 0;

  logic [255:0] e_zero, e_dc, e_pos, e_neg, e_w4, e_wm1;
  logic [127:0] sv;
  logic [191:0] dv;
  int           ev [16];

  always #5 clk = ~clk;

  ftransform_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_mode_i  (in_mode),
    .in_tag_i   (in_tag),
    .src_i      (src),
    .ref_i      (ref_v),
    .dc_i       (dc),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_mode_o (out_mode),
    .out_tag_o  (out_tag),
    .out_o      (out_v)
`ifdef FTX_NZ_EN
    ,
    .out_nz_o   (out_nz)
`endif
  );

  function automatic logic [127:0] rep8(input int v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [191:0] rep12(input int v);
    logic [191:0] r;
    for (int k = 0; k < 16; k++) r[12*k +: 12] = 12'(v);
    return r;
  endfunction

  function automatic logic [255:0] pk(input int v [16]);
    logic [255:0] r;
    for (int k = 0; k < 16; k++) r[16*k +: 16] = 16'(v[k]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic single(input string nm, input logic m, input logic [3:0] tg,
                        input logic [127:0] s, input logic [127:0] r,
                        input logic [191:0] d, input logic [255:0] exp);
    @(posedge clk); #1;
    in_mode = m; in_tag = tg; src = s; ref_v = r; dc = d;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({nm, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "_not_early"}, out_valid, 1'b0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_out"}, out_v, exp);
    chk({nm, "_tag"}, out_tag, tg);
    chk({nm, "_mode"}, out_mode, m);
  endtask

  task automatic stream(input string nm, input int n, input bit mixed, input int stall_len);
    int sent, got, stall_left, first_c, last_c;
    bit seen, rdy_low, holding, exp_mode;
    logic [3:0]   held_tag;
    logic [255:0] held_out;
    sent = 0; got = 0; stall_left = 0; first_c = -1; last_c = -1;
    seen = 0; rdy_low = 0; holding = 0;
    held_tag = '0; held_out = '0;
    src = rep8(101); ref_v = rep8(100); dc = rep12(4);
    for (int c = 0; c < 60 && got < n; c++) begin
      @(posedge clk); #1;
      if (out_valid && !seen) begin seen = 1; stall_left = stall_len; end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      in_valid = (sent < n);
      in_tag   = 4'(sent);
      in_mode  = mixed && sent[0];
      #1;
      if (!in_ready) rdy_low = 1;
      if (out_valid && holding) begin
        chk({nm, "_hold_tag"}, out_tag, held_tag);
        chk({nm, "_hold_out"}, out_v, held_out);
      end
      holding = out_valid && !out_ready;
      if (holding) begin held_tag = out_tag; held_out = out_v; end
      if (out_valid && out_ready) begin
        exp_mode = mixed && got[0];
        chk({nm, "_order_tag"}, out_tag, 4'(got));
        chk({nm, "_mode"}, out_mode, exp_mode);
        chk({nm, "_data"}, out_v, exp_mode ? e_w4 : e_dc);
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk({nm, "_beat_count"}, got, n);
    if (stall_len > 0) chk({nm, "_in_ready_dropped"}, rdy_low, 1'b1);
    else               chk({nm, "_one_per_cycle"}, last_c - first_c, n - 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk({nm, "_no_duplicate"}, out_valid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    ev = '{default: 0}; ev[1] = 1;                          e_zero = pk(ev);
    ev = '{default: 0}; ev[0] = 8; ev[1] = 1;               e_dc   = pk(ev);
    ev = '{5, 7, 5, 3, 7, 9, 7, 4, 5, 7, 5, 3, 3, 4, 3, 2}; e_pos  = pk(ev);
    ev = '{-5, -6, -5, -2, -6, -8, -6, -3, -5, -7, -5, -3, -2, -3, -2, -1};
    e_neg = pk(ev);
    ev = '{default: 0}; ev[0] = 32;                         e_w4   = pk(ev);
    ev = '{default: -1};                                    e_wm1  = pk(ev);

    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_tag = '0;
    src = '0; ref_v = '0; dc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out", out_v, '0);
    chk("rst_tag", out_tag, '0);
    chk("rst_mode", out_mode, 1'b0);
`ifdef FTX_NZ_EN
    chk("rst_nz", out_nz, '0);
`endif
    #2 rst_n = 1'b1;

    // A zero residual still leaves the row rounding term, which lands as 1 in lane 1.
    single("dct_zero", 1'b0, 4'd3, rep8(128), rep8(128), rep12(5), e_zero);
    single("dct_dc", 1'b0, 4'd1, rep8(101), rep8(100), rep12(0), e_dc);
`ifdef FTX_NZ_EN
    chk("dct_dc_nz", out_nz, 16'h0003);
`endif
    sv = rep8(100); sv[7:0] = 8'd110;
    single("dct_pos", 1'b0, 4'd2, sv, rep8(100), rep12(3), e_pos);
    sv = rep8(100); sv[7:0] = 8'd90;
    single("dct_neg", 1'b0, 4'd4, sv, rep8(100), rep12(0), e_neg);
`ifdef FTX_NZ_EN
    chk("dct_neg_nz", out_nz, 16'hFFFF);
`endif
    single("wht_flat", 1'b1, 4'd7, rep8(33), rep8(200), rep12(4), e_w4);
    dv = '0; dv[11:0] = 12'hFFE;
    single("wht_neg", 1'b1, 4'd8, rep8(0), rep8(255), dv, e_wm1);

    stream("bp", 6, 1'b0, 4);
    stream("mix", 8, 1'b1, 0);

    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_tag = 4'd9;
    src = rep8(101); ref_v = rep8(100);
    @(posedge clk); #1;
    in_tag = 4'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_inflight_pre", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_out", out_v, '0);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("rst_no_stale", out_valid, 1'b0);
    end
    chk("rst_post_in_ready", in_ready, 1'b1);
    single("post_rst_dc", 1'b0, 4'd5, rep8(101), rep8(100), rep12(0), e_dc);
`ifdef FTX_NZ_EN
    chk("post_rst_nz", out_nz, 16'h0003);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
